// File: rtl/mem_stage_ctrl_if.sv
// Bundle between the EX/MEM register, the data memory and the MEM/WB register.
// The DUT uses the slave modport; the upstream/memory environment uses master.
interface mem_stage_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              ex_valid;
    logic              ex_memread;
    logic              ex_memwrite;
    logic              ex_regwrite;
    logic [RD_W-1:0]   ex_rd;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_wdata;
    logic              stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic              wb_regwrite;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_rd,
               ex_alu_result, ex_wdata, mem_rdata,
        input  stall, mem_read, mem_write, mem_addr, mem_wdata,
               wb_valid, wb_regwrite, wb_rd, wb_data
    );

    modport slave (
        input  ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_rd,
               ex_alu_result, ex_wdata, mem_rdata,
        output stall, mem_read, mem_write, mem_addr, mem_wdata,
               wb_valid, wb_regwrite, wb_rd, wb_data
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: drives data-memory strobes, stalls one cycle per load, registers MEM/WB.
// Optional last-store forwarding buffer is enabled by defining LOAD_FWD_EN.
module mem_stage_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    mem_stage_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    logic              wb_valid_r;
    logic              wb_regwrite_r;
    logic [RD_W-1:0]   wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;

    logic              ld_s;
    logic              st_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_rdata_s;
    logic              read_s;
    logic              write_s;
    logic              stall_s;
    logic [ADDR_W-1:0] addr_s;

`ifdef LOAD_FWD_EN
    logic              fwd_valid_r;
    logic [ADDR_W-1:0] fwd_addr_r;
    logic [DATA_W-1:0] fwd_data_r;
`endif

    // Decode the presented op and generate strobes/stall; all forced low during reset.
    always_comb begin
        ld_s        = bus.ex_valid & bus.ex_memread;
        st_s        = bus.ex_valid & bus.ex_memwrite & ~bus.ex_memread;
        addr_s      = bus.ex_alu_result[ADDR_W-1:0];
`ifdef LOAD_FWD_EN
        fwd_hit_s   = fwd_valid_r & (addr_s == fwd_addr_r);
        fwd_rdata_s = fwd_data_r;
`else
        fwd_hit_s   = 1'b0;
        fwd_rdata_s = {DATA_W{1'b0}};
`endif
        read_s      = 1'b0;
        write_s     = 1'b0;
        stall_s     = 1'b0;
        if (reset) begin
            read_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ld_s && !fwd_hit_s) begin
                        read_s  = 1'b1;
                        stall_s = 1'b1;
                    end else if (st_s) begin
                        write_s = 1'b1;
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                LOAD_WAIT: stall_s = 1'b0;
                default:   stall_s = 1'b0;
            endcase
        end
    end

    assign bus.stall       = stall_s;
    assign bus.mem_read    = read_s;
    assign bus.mem_write   = write_s;
    assign bus.mem_addr    = addr_s;
    assign bus.mem_wdata   = bus.ex_wdata;
    assign bus.wb_valid    = wb_valid_r;
    assign bus.wb_regwrite = wb_regwrite_r;
    assign bus.wb_rd       = wb_rd_r;
    assign bus.wb_data     = wb_data_r;

    // Sequencer state and MEM/WB register; a load waiting on memory is dropped by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            wb_valid_r    <= 1'b0;
            wb_regwrite_r <= 1'b0;
            wb_rd_r       <= {RD_W{1'b0}};
            wb_data_r     <= {DATA_W{1'b0}};
`ifdef LOAD_FWD_EN
            fwd_valid_r   <= 1'b0;
            fwd_addr_r    <= {ADDR_W{1'b0}};
            fwd_data_r    <= {DATA_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (ld_s && !fwd_hit_s) begin
                        // Bubble while memory produces the word.
                        wb_valid_r    <= 1'b0;
                        wb_regwrite_r <= 1'b0;
                        state_r       <= LOAD_WAIT;
                    end else if (ld_s) begin
                        wb_valid_r    <= 1'b1;
                        wb_regwrite_r <= bus.ex_regwrite;
                        wb_rd_r       <= bus.ex_rd;
                        wb_data_r     <= fwd_rdata_s;
                    end else if (st_s) begin
                        wb_valid_r    <= 1'b1;
                        wb_regwrite_r <= 1'b0;
                        wb_rd_r       <= bus.ex_rd;
                        wb_data_r     <= bus.ex_alu_result;
`ifdef LOAD_FWD_EN
                        fwd_valid_r   <= 1'b1;
                        fwd_addr_r    <= addr_s;
                        fwd_data_r    <= bus.ex_wdata;
`endif
                    end else if (bus.ex_valid) begin
                        wb_valid_r    <= 1'b1;
                        wb_regwrite_r <= bus.ex_regwrite;
                        wb_rd_r       <= bus.ex_rd;
                        wb_data_r     <= bus.ex_alu_result;
                    end else begin
                        wb_valid_r    <= 1'b0;
                        wb_regwrite_r <= 1'b0;
                    end
                end
                LOAD_WAIT: begin
                    wb_valid_r    <= 1'b1;
                    wb_regwrite_r <= bus.ex_regwrite;
                    wb_rd_r       <= bus.ex_rd;
                    wb_data_r     <= bus.mem_rdata;
                    state_r       <= IDLE;
                end
                default: begin
                    wb_valid_r    <= 1'b0;
                    wb_regwrite_r <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a registered-read 256-word memory model.
module tb_mem_stage_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem_model [0:255];

    mem_stage_ctrl_if #(.ADDR_W(8), .DATA_W(32), .RD_W(5)) bus ();

    mem_stage_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: write on strobe, read data valid the cycle after mem_read.
    always @(posedge clk) begin
        if (bus.mem_write) mem_model[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= mem_model[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic rd_en, input logic wr_en, input logic rw,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
        bus.ex_valid      = v;
        bus.ex_memread    = rd_en;
        bus.ex_memwrite   = wr_en;
        bus.ex_regwrite   = rw;
        bus.ex_rd         = rd;
        bus.ex_alu_result = alu;
        bus.ex_wdata      = wd;
        #1;
    endtask

    task automatic idle();
        present(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        step();
        step();

        // ALU op writes back one cycle later with no memory activity.
        reset = 1'b0;
        present(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000DEAD, 32'h0);
        check("alu_no_read",  {31'd0, bus.mem_read},  32'd0);
        check("alu_no_write", {31'd0, bus.mem_write}, 32'd0);
        check("alu_no_stall", {31'd0, bus.stall},     32'd0);
        step();
        check("alu_wb_valid", {31'd0, bus.wb_valid},    32'd1);
        check("alu_wb_rw",    {31'd0, bus.wb_regwrite}, 32'd1);
        check("alu_wb_rd",    {27'd0, bus.wb_rd},       32'd3);
        check("alu_wb_data",  bus.wb_data,              32'h0000DEAD);

        // Reset mid-run while a load is presented.
        present(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'h00000050, 32'h0);
        check("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_stall",    {31'd0, bus.stall},       32'd0);
        check("rst_read",     {31'd0, bus.mem_read},    32'd0);
        check("rst_write",    {31'd0, bus.mem_write},   32'd0);
        check("rst_wb_valid", {31'd0, bus.wb_valid},    32'd0);
        check("rst_wb_rw",    {31'd0, bus.wb_regwrite}, 32'd0);
        check("rst_wb_rd",    {27'd0, bus.wb_rd},       32'd0);
        check("rst_wb_data",  bus.wb_data,              32'd0);
        step();
        reset = 1'b0;
        idle();
        step();
        check("idle_wb_valid", {31'd0, bus.wb_valid}, 32'd0);

        // Store 0x10 then load 0x10.
        present(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h00000010, 32'h12345678);
        check("st_write", {31'd0, bus.mem_write}, 32'd1);
        check("st_read",  {31'd0, bus.mem_read},  32'd0);
        check("st_stall", {31'd0, bus.stall},     32'd0);
        check("st_addr",  {24'd0, bus.mem_addr},  32'h00000010);
        check("st_wdata", bus.mem_wdata,          32'h12345678);
        step();
        check("st_wb_valid", {31'd0, bus.wb_valid},    32'd1);
        check("st_wb_rw",    {31'd0, bus.wb_regwrite}, 32'd0);
        check("st_wb_rd",    {27'd0, bus.wb_rd},       32'd7);
        check("st_wb_data",  bus.wb_data,              32'h00000010);
        present(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h00000010, 32'h0);
`ifdef LOAD_FWD_EN
        check("ld10_stall", {31'd0, bus.stall},    32'd0);
        check("ld10_read",  {31'd0, bus.mem_read}, 32'd0);
        step();
`else
        check("ld10_stall", {31'd0, bus.stall},    32'd1);
        check("ld10_read",  {31'd0, bus.mem_read}, 32'd1);
        step();
        check("ld10_bubble",     {31'd0, bus.wb_valid}, 32'd0);
        check("ld10_wait_stall", {31'd0, bus.stall},    32'd0);
        check("ld10_wait_read",  {31'd0, bus.mem_read}, 32'd0);
        step();
`endif
        check("ld10_wb_valid", {31'd0, bus.wb_valid},    32'd1);
        check("ld10_wb_rw",    {31'd0, bus.wb_regwrite}, 32'd1);
        check("ld10_wb_rd",    {27'd0, bus.wb_rd},       32'd4);
        check("ld10_wb_data",  bus.wb_data,              32'h12345678);
        idle();
        step();
        check("hold_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("hold_wb_rd",    {27'd0, bus.wb_rd},    32'd4);

        // Store 0x20 then load 0x20 (forwarded if enabled), then load 0x21.
        present(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h00000020, 32'hA5A5A5A5);
        step();
        present(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h00000020, 32'h0);
`ifdef LOAD_FWD_EN
        check("ld20_stall", {31'd0, bus.stall},    32'd0);
        check("ld20_read",  {31'd0, bus.mem_read}, 32'd0);
        step();
        check("ld20_wb_data", bus.wb_data,         32'hA5A5A5A5);
        check("ld20_wb_rd",   {27'd0, bus.wb_rd},  32'd8);
        present(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h00000021, 32'h0);
        check("ld21_stall", {31'd0, bus.stall},    32'd1);
        check("ld21_read",  {31'd0, bus.mem_read}, 32'd1);
        step();
        step();
        check("ld21_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("ld21_wb_rd",    {27'd0, bus.wb_rd},    32'd10);
`else
        check("ld20_stall", {31'd0, bus.stall},    32'd1);
        check("ld20_read",  {31'd0, bus.mem_read}, 32'd1);
        step();
        step();
        check("ld20_wb_data", bus.wb_data,        32'hA5A5A5A5);
        check("ld20_wb_rd",   {27'd0, bus.wb_rd}, 32'd8);
`endif
        idle();
        step();

        // Read and write both set: only the read happens, memory keeps its word.
        present(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h00000030, 32'hCAFEF00D);
        step();
        present(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h00000031, 32'h11112222);
        step();
        present(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h00000030, 32'hBAD0BAD0);
        check("rw_read",  {31'd0, bus.mem_read},  32'd1);
        check("rw_write", {31'd0, bus.mem_write}, 32'd0);
        check("rw_stall", {31'd0, bus.stall},     32'd1);
        step();
        check("rw_wait_write", {31'd0, bus.mem_write}, 32'd0);
        check("rw_wait_read",  {31'd0, bus.mem_read},  32'd0);
        step();
        check("rw_wb_data", bus.wb_data,        32'hCAFEF00D);
        check("rw_wb_rd",   {27'd0, bus.wb_rd}, 32'd5);
        present(1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h00000030, 32'h0);
        step();
        step();
        check("mem30_kept", bus.wb_data, 32'hCAFEF00D);
        idle();
        step();

        // Reset during LOAD_WAIT: no capture, load reissues afterwards.
        present(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h00000040, 32'h0BADF00D);
        step();
        present(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h00000041, 32'h00000000);
        step();
        present(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h00000040, 32'h0);
        step();
        check("lw_stall", {31'd0, bus.stall}, 32'd0);
        reset = 1'b1;
        #1;
        check("lw_rst_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("lw_rst_stall", {31'd0, bus.stall},    32'd0);
        check("lw_rst_read",  {31'd0, bus.mem_read}, 32'd0);
        step();
        check("lw_rst_hold_valid", {31'd0, bus.wb_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("lw_reissue_stall", {31'd0, bus.stall},    32'd1);
        check("lw_reissue_read",  {31'd0, bus.mem_read}, 32'd1);
        step();
        check("lw_reissue_bubble", {31'd0, bus.wb_valid}, 32'd0);
        step();
        check("lw_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("lw_wb_rd",    {27'd0, bus.wb_rd},    32'd9);
        check("lw_wb_data",  bus.wb_data,           32'h0BADF00D);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
